icache_dm: RTL and testbench

- Parametrised direct-mapped instruction cache between the IF stage and Mem_ctrl instruction port; generalises the single-word fetch path to multi-word lines with configurable depth.
- Hits return in 1 cycle; misses refill a whole line by sequential word requests to Mem_ctrl, then respond.
- Flush input invalidates all lines (e.g. on fence.i or program reload).

---
 rtl/icache_dm_if.sv | 24 ++
 rtl/icache_dm.sv | 180 ++++++++++++++++++
 tb/tb_icache_dm.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/icache_dm_if.sv
// Fetch-side and Mem_ctrl-side bus of the direct-mapped instruction cache.
// slave = cache view, master = IF stage / memory model view.
interface icache_dm_if;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        flush;
    logic        resp_valid;
    logic [31:0] resp_addr;
    logic [31:0] resp_instr;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_done;
    logic [31:0] mem_data;

    modport slave (
        input  req_valid, req_addr, flush, mem_done, mem_data,
        output resp_valid, resp_addr, resp_instr, mem_req, mem_addr
    );

    modport master (
        output req_valid, req_addr, flush, mem_done, mem_data,
        input  resp_valid, resp_addr, resp_instr, mem_req, mem_addr
    );
endinterface

// File: rtl/icache_dm.sv
// Direct-mapped instruction cache: 1-cycle hits, whole-line refill on miss, global flush.
// Optional ICACHE_STATS_EN adds hit_count/miss_count outputs.
module icache_dm #(
    parameter int LINES      = 64,
    parameter int LINE_WORDS = 4,
    parameter int ADDR_WIDTH = 18
) (
    input  logic        clk,
    input  logic        rst,
    icache_dm_if.slave  bus
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);
    localparam int OFF   = $clog2(LINE_WORDS);
    localparam int IDX   = $clog2(LINES);
    localparam int DW    = OFF + IDX;
    localparam int TAG_W = ADDR_WIDTH - 2 - DW;
    localparam int CNT_W = (OFF > 0) ? OFF : 1;
    localparam logic [31:0] LINE_MASK = 32'(LINE_WORDS * 4 - 1);
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(LINE_WORDS - 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_REFILL  = 2'd1;
    localparam logic [1:0] S_RESPOND = 2'd2;

    logic [TAG_W-1:0] tag_mem  [LINES];
    logic [31:0]      data_mem [LINES*LINE_WORDS];

    logic [LINES-1:0] valid_q, valid_d;
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             abort_q, abort_d;
    logic             mem_req_q, mem_req_d;
    logic [31:0]      mem_addr_q, mem_addr_d;
    logic [31:0]      lat_addr_q, lat_addr_d;
    logic             resp_valid_q, resp_valid_d;
    logic [31:0]      resp_addr_q, resp_addr_d;
    logic [31:0]      resp_instr_q, resp_instr_d;
    logic             data_we, tag_we, lookup_hit;

    // The data array is word-indexed, so addr[2+DW-1:2] is {line index, word select}.
    logic [IDX-1:0]   req_idx, fill_idx;
    logic [TAG_W-1:0] req_tag, fill_tag;
    logic [DW-1:0]    req_didx, fill_didx, lat_didx;

    assign req_idx    = bus.req_addr[2+DW-1:2+OFF];
    assign req_tag    = bus.req_addr[ADDR_WIDTH-1:2+DW];
    assign req_didx   = bus.req_addr[2+DW-1:2];
    assign fill_idx   = lat_addr_q[2+DW-1:2+OFF];
    assign fill_tag   = lat_addr_q[ADDR_WIDTH-1:2+DW];
    assign fill_didx  = mem_addr_q[2+DW-1:2];
    assign lat_didx   = lat_addr_q[2+DW-1:2];
    assign lookup_hit = valid_q[req_idx] && (tag_mem[req_idx] == req_tag);

    logic unused_addr_bits;
    if (ADDR_WIDTH < 32) begin : g_hi_unused
        assign unused_addr_bits = ^{bus.req_addr[31:ADDR_WIDTH], bus.req_addr[1:0]};
    end else begin : g_hi_used
        assign unused_addr_bits = ^bus.req_addr[1:0];
    end

    always_comb begin
        state_d      = state_q;
        valid_d      = valid_q;
        cnt_d        = cnt_q;
        abort_d      = abort_q;
        mem_req_d    = mem_req_q;
        mem_addr_d   = mem_addr_q;
        lat_addr_d   = lat_addr_q;
        resp_valid_d = 1'b0;
        resp_addr_d  = resp_addr_q;
        resp_instr_d = resp_instr_q;
        data_we      = 1'b0;
        tag_we       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.req_valid) begin
                    if (lookup_hit && !bus.flush) begin
                        resp_valid_d = 1'b1;
                        resp_addr_d  = bus.req_addr & ~32'h3;
                        resp_instr_d = data_mem[req_didx];
                    end else begin
                        // Line is invalidated up front so a partial refill can never look valid.
                        valid_d[req_idx] = 1'b0;
                        lat_addr_d = bus.req_addr;
                        mem_addr_d = bus.req_addr & ~LINE_MASK;
                        cnt_d      = '0;
                        abort_d    = 1'b0;
                        mem_req_d  = 1'b1;
                        state_d    = S_REFILL;
                    end
                end
            end
            S_REFILL: begin
                if (bus.flush) abort_d = 1'b1;
                if (bus.mem_done) begin
                    data_we = 1'b1;
                    if (abort_q || bus.flush) begin
                        mem_req_d = 1'b0;
                        abort_d   = 1'b0;
                        state_d   = S_IDLE;
                    end else if (cnt_q == LAST_WORD) begin
                        valid_d[fill_idx] = 1'b1;
                        tag_we    = 1'b1;
                        mem_req_d = 1'b0;
                        state_d   = S_RESPOND;
                    end else begin
                        cnt_d      = cnt_q + 1'b1;
                        mem_addr_d = mem_addr_q + 32'd4;
                    end
                end
            end
            S_RESPOND: begin
                resp_valid_d = 1'b1;
                resp_addr_d  = lat_addr_q & ~32'h3;
                resp_instr_d = data_mem[lat_didx];
                state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (bus.flush) valid_d = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            valid_q      <= '0;
            cnt_q        <= '0;
            abort_q      <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_addr_q   <= '0;
            lat_addr_q   <= '0;
            resp_valid_q <= 1'b0;
            resp_addr_q  <= '0;
            resp_instr_q <= '0;
        end else begin
            state_q      <= state_d;
            valid_q      <= valid_d;
            cnt_q        <= cnt_d;
            abort_q      <= abort_d;
            mem_req_q    <= mem_req_d;
            mem_addr_q   <= mem_addr_d;
            lat_addr_q   <= lat_addr_d;
            resp_valid_q <= resp_valid_d;
            resp_addr_q  <= resp_addr_d;
            resp_instr_q <= resp_instr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (data_we) data_mem[fill_didx] <= bus.mem_data;
        if (tag_we)  tag_mem[fill_idx]   <= fill_tag;
    end

    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_addr  = resp_addr_q;
    assign bus.resp_instr = resp_instr_q;
    assign bus.mem_req    = mem_req_q;
    assign bus.mem_addr   = mem_addr_q;

`ifdef ICACHE_STATS_EN
    logic [31:0] hit_cnt_q, miss_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (state_q == S_IDLE && resp_valid_d) hit_cnt_q <= hit_cnt_q + 32'd1;
            if (state_q == S_IDLE && state_d == S_REFILL) miss_cnt_q <= miss_cnt_q + 32'd1;
        end
    end

    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;
`endif
endmodule

// File: tb/tb_icache_dm.sv
// Directed bench for icache_dm with a response/refill-address scoreboard and a
// behavioural Mem_ctrl model with random latency.
module tb_icache_dm;
    logic clk = 1'b0;
    logic rst;

    icache_dm_if bus();

`ifdef ICACHE_STATS_EN
    logic [31:0] hit_count, miss_count;
`endif

    icache_dm #(.LINES(64), .LINE_WORDS(4), .ADDR_WIDTH(18)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
`ifdef ICACHE_STATS_EN
        ,
        .hit_count(hit_count),
        .miss_count(miss_count)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;
    int fails  = 0;
    logic [63:0] exp_resp[$];
    logic [31:0] exp_mem[$];
    int done_cnt = 0;
    int resp_cnt = 0;

    function automatic logic [31:0] mdata(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'hC0DE0000;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Mem_ctrl model: answers each held mem_req after 0..2 idle cycles.
    initial begin
        int gap;
        gap = 0;
        bus.mem_done = 1'b0;
        bus.mem_data = '0;
        forever begin
            @(negedge clk);
            bus.mem_done = 1'b0;
            if (rst === 1'b0 && bus.mem_req === 1'b1) begin
                if (gap > 0) gap--;
                else begin
                    check("mem_req_expected", 32'(exp_mem.size() > 0), 32'd1);
                    if (exp_mem.size() > 0) check("mem_addr", bus.mem_addr, exp_mem.pop_front());
                    bus.mem_done = 1'b1;
                    bus.mem_data = mdata(bus.mem_addr);
                    done_cnt++;
                    gap = $urandom_range(0, 2);
                end
            end
        end
    end

    initial begin
        logic [63:0] e;
        forever begin
            @(negedge clk);
            if (bus.resp_valid === 1'b1) begin
                resp_cnt++;
                check("resp_expected", 32'(exp_resp.size() > 0), 32'd1);
                if (exp_resp.size() > 0) begin
                    e = exp_resp.pop_front();
                    check("resp_addr", bus.resp_addr, e[63:32]);
                    check("resp_instr", bus.resp_instr, e[31:0]);
                end
            end
        end
    end

    task automatic fetch(input logic [31:0] a, input bit miss, input bit with_flush, input string tag);
        int d0, cyc;
        d0 = done_cnt;
        exp_resp.push_back({a & ~32'h3, mdata(a & ~32'h3)});
        if (miss) for (int i = 0; i < 4; i++) exp_mem.push_back((a & ~32'hF) + 32'(i * 4));
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_addr  = a;
        bus.flush     = with_flush;
        cyc = 0;
        do begin
            @(negedge clk);
            bus.flush = 1'b0;
            cyc++;
        end while (bus.resp_valid !== 1'b1 && cyc < 200);
        bus.req_valid = 1'b0;
        check({tag, "_responded"}, 32'(bus.resp_valid), 32'd1);
        if (!miss) check({tag, "_hit_latency"}, 32'(cyc), 32'd1);
        check({tag, "_mem_words"}, 32'(done_cnt - d0), miss ? 32'd4 : 32'd0);
    endtask

    initial begin
        int d0, r0, cyc;
        rst = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_addr  = '0;
        bus.flush     = 1'b0;
        #12;
        check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        check("rst_mem_req", 32'(bus.mem_req), 32'd0);
        check("rst_mem_addr", bus.mem_addr, 32'd0);
        check("rst_resp_addr", bus.resp_addr, 32'd0);
        check("rst_resp_instr", bus.resp_instr, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        fetch(32'h104, 1'b1, 1'b0, "cold_miss");
        fetch(32'h10C, 1'b0, 1'b0, "hit_10c");
        fetch(32'h108, 1'b0, 1'b0, "hit_108");

        // Back-to-back hits with the address changing in each response cycle.
        for (int i = 0; i < 3; i++) exp_resp.push_back({32'h100 + 32'(i * 4), mdata(32'h100 + 32'(i * 4))});
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_addr  = 32'h100;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            check("b2b_resp_valid", 32'(bus.resp_valid), 32'd1);
            bus.req_addr = 32'h100 + 32'(i * 4);
        end
        bus.req_valid = 1'b0;

        fetch(32'h500, 1'b1, 1'b0, "conflict_500");
        fetch(32'h100, 1'b1, 1'b0, "evicted_100");

        // Flush after the 2nd refill word: no response, refill stops at the 3rd word.
        d0 = done_cnt;
        r0 = resp_cnt;
        for (int i = 0; i < 3; i++) exp_mem.push_back(32'h2000 + 32'(i * 4));
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_addr  = 32'h2000;
        cyc = 0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
        end while (done_cnt - d0 < 2 && cyc < 100);
        check("flush_two_words", 32'(done_cnt - d0), 32'd2);
        bus.flush     = 1'b1;
        bus.req_valid = 1'b0;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        if (done_cnt - d0 == 2) check("flush_mem_req_held", 32'(bus.mem_req), 32'd1);
        repeat (10) @(posedge clk);
        #1;
        check("flush_words_total", 32'(done_cnt - d0), 32'd3);
        check("flush_mem_req_drop", 32'(bus.mem_req), 32'd0);
        check("flush_no_resp", 32'(resp_cnt - r0), 32'd0);
        check("flush_mem_drained", 32'(exp_mem.size()), 32'd0);
        fetch(32'h2000, 1'b1, 1'b0, "after_flush_2000");

        fetch(32'h104, 1'b1, 1'b1, "flush_beats_hit");
        fetch(32'h100, 1'b0, 1'b0, "refilled_hit_100");

        // Asynchronous reset in the middle of a refill.
        d0 = done_cnt;
        exp_mem.push_back(32'h3000);
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_addr  = 32'h3004;
        cyc = 0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
        end while (done_cnt - d0 < 1 && cyc < 100);
        #2;
        rst = 1'b1;
        #1;
        check("arst_mem_req", 32'(bus.mem_req), 32'd0);
        check("arst_resp_valid", 32'(bus.resp_valid), 32'd0);
        check("arst_mem_addr", bus.mem_addr, 32'd0);
        bus.req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("arst_one_word", 32'(done_cnt - d0), 32'd1);
        check("arst_mem_drained", 32'(exp_mem.size()), 32'd0);
`ifdef ICACHE_STATS_EN
        check("stats_rst_hit", hit_count, 32'd0);
        check("stats_rst_miss", miss_count, 32'd0);
`endif
        fetch(32'h104, 1'b1, 1'b0, "after_rst_104");

        fetch(32'h0, 1'b1, 1'b0, "stats_miss_0");
        fetch(32'h4, 1'b0, 1'b0, "stats_hit_4");
        fetch(32'h8, 1'b0, 1'b0, "stats_hit_8");
        fetch(32'h40, 1'b1, 1'b0, "stats_miss_40");
`ifdef ICACHE_STATS_EN
        check("stats_hit", hit_count, 32'd2);
        check("stats_miss", miss_count, 32'd3);
`endif
        @(negedge clk);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
`ifdef ICACHE_STATS_EN
        check("stats_hit_flush", hit_count, 32'd2);
        check("stats_miss_flush", miss_count, 32'd3);
`endif
        fetch(32'h4, 1'b1, 1'b0, "post_flush_4");

        repeat (5) @(negedge clk);
        check("resp_drained", 32'(exp_resp.size()), 32'd0);
        check("mem_drained", 32'(exp_mem.size()), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
